// File: rtl/clkdiv_pkg.sv
// ----------------------------------------------------------------------------
// clkdiv_pkg
// Shared types for the clock-divider bank: default counter width, the counter
// type and the per-channel configuration payload {period, high}.
// ----------------------------------------------------------------------------
package clkdiv_pkg;

    localparam int unsigned CW_DEFAULT = 28;

    typedef logic [CW_DEFAULT-1:0] cnt_t;

    typedef struct packed {
        cnt_t period;
        cnt_t high;
    } ch_cfg_t;

endpackage : clkdiv_pkg

// File: rtl/clkdiv_if.sv
// ----------------------------------------------------------------------------
// clkdiv_if
// Configuration-load handshake for clkdiv_bank.
//   load_valid  : master requests a write of {load_period, load_high}
//   load_ready  : slave accepts when high together with load_valid
//   load_ch     : target channel index
//   load_period : new period (clock_in cycles)
//   load_high   : new high-time (clock_in cycles)
// ----------------------------------------------------------------------------
interface clkdiv_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = clkdiv_pkg::CW_DEFAULT
);
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           load_valid;
    logic           load_ready;
    logic [CHW-1:0] load_ch;
    logic [CW-1:0]  load_period;
    logic [CW-1:0]  load_high;

    modport master (
        output load_valid,
        output load_ch,
        output load_period,
        output load_high,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_ch,
        input  load_period,
        input  load_high,
        output load_ready
    );

endinterface : clkdiv_if

// File: rtl/clkdiv_channel.sv
// ----------------------------------------------------------------------------
// clkdiv_channel
// One divider channel: active period/high-time, counter, run flag, shadow
// configuration with pending flag, and registered clock_out/tick.
// Optional feature: define CLKDIV_SYNC_EN to add sync_in, which restarts the
// channel at count 0 and applies any pending shadow.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : run enable
//   sync_in     : (CLKDIV_SYNC_EN only) bank-wide phase restart
//   ld_we       : accepted config write for this channel
//   ld_period   : new period
//   ld_high     : new high-time
//   pending     : shadow waiting to be applied (registered)
//   clock_out   : divided square wave (registered)
//   tick        : one-cycle pulse at period start (registered)
// ----------------------------------------------------------------------------
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned CW         = CW_DEFAULT,
    parameter int unsigned DEF_PERIOD = 2000,
    parameter int unsigned DEF_HIGH   = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
`ifdef CLKDIV_SYNC_EN
    input  logic          sync_in,
`endif
    input  logic          ld_we,
    input  logic [CW-1:0] ld_period,
    input  logic [CW-1:0] ld_high,
    output logic          pending,
    output logic          clock_out,
    output logic          tick
);

    localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);
    localparam logic [CW-1:0] DEF_H = CW'(DEF_HIGH);

    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic [CW-1:0] sh_period_q, sh_period_d;
    logic [CW-1:0] sh_high_q, sh_high_d;
    logic          pend_q, pend_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;

    logic          apply_c;
    logic [CW-1:0] eff_period_c;
    logic [CW-1:0] eff_high_c;

    // Next-state: counter, run flag, shadow/pending and registered outputs
    always_comb begin
        period_d    = period_q;
        high_d      = high_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        sh_period_d = sh_period_q;
        sh_high_d   = sh_high_q;
        pend_d      = pend_q;
        clk_d       = 1'b0;
        tick_d      = 1'b0;
        apply_c     = 1'b0;

        // Config the next period starts with if the shadow is applied now
        eff_period_c = pend_q ? sh_period_q : period_q;
        eff_high_c   = pend_q ? sh_high_q   : high_q;

        if (!en) begin
            cnt_d   = '0;
            run_d   = 1'b0;
            apply_c = pend_q;
`ifdef CLKDIV_SYNC_EN
        end else if (sync_in) begin
            // A zero period stays halted even across a sync restart
            apply_c = pend_q;
            cnt_d   = '0;
            if (eff_period_c == '0) begin
                run_d = 1'b0;
            end else begin
                run_d  = 1'b1;
                tick_d = 1'b1;
                clk_d  = (eff_high_c != '0);
            end
`endif
        end else if (period_q == '0) begin
            // Halted; dropping the run flag makes a later load restart with a tick
            cnt_d   = '0;
            run_d   = 1'b0;
            apply_c = pend_q;
        end else if (!run_q) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = (high_q != '0);
        end else if (cnt_q == period_q - CW'(1)) begin
            // Wrap: the only glitch-free point to switch config while running
            cnt_d   = '0;
            apply_c = pend_q;
            tick_d  = 1'b1;
            clk_d   = (eff_high_c != '0);
        end else begin
            cnt_d = cnt_q + CW'(1);
            clk_d = (cnt_d < high_q);
        end

        if (apply_c) begin
            period_d = sh_period_q;
            high_d   = sh_high_q;
            pend_d   = 1'b0;
        end

        // Writes are only granted while nothing is pending, so never collide with apply
        if (ld_we) begin
            sh_period_d = ld_period;
            sh_high_d   = ld_high;
            pend_d      = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q    <= DEF_P;
            high_q      <= DEF_H;
            cnt_q       <= '0;
            run_q       <= 1'b0;
            sh_period_q <= DEF_P;
            sh_high_q   <= DEF_H;
            pend_q      <= 1'b0;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            period_q    <= period_d;
            high_q      <= high_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            sh_period_q <= sh_period_d;
            sh_high_q   <= sh_high_d;
            pend_q      <= pend_d;
            clk_q       <= clk_d;
            tick_q      <= tick_d;
        end
    end

    assign pending   = pend_q;
    assign clock_out = clk_q;
    assign tick      = tick_q;

endmodule : clkdiv_channel

// File: rtl/clkdiv_bank.sv
// ----------------------------------------------------------------------------
// clkdiv_bank
// Bank of NCH programmable clock dividers with a shared config-load port.
// Optional feature: define CLKDIV_SYNC_EN to add sync_in, which restarts all
// enabled channels on the same edge.
//   clock_in   : sole clock
//   reset_n    : asynchronous active-low reset
//   en         : per-channel run enable
//   sync_in    : (CLKDIV_SYNC_EN only) phase-align all enabled channels
//   ld         : clkdiv_if slave - load_valid/load_ready/load_ch/period/high
//   clock_out  : divided square waves (registered)
//   tick       : one-cycle pulse at each period start (registered)
// load_ready is combinational: low while the addressed channel has a pending
// shadow that has not yet been applied.
// ----------------------------------------------------------------------------
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CW         = CW_DEFAULT,
    parameter int unsigned DEF_PERIOD = 2000,
    parameter int unsigned DEF_HIGH   = 1000
) (
    input  logic           clock_in,
    input  logic           reset_n,
    input  logic [NCH-1:0] en,
`ifdef CLKDIV_SYNC_EN
    input  logic           sync_in,
`endif
    clkdiv_if.slave        ld,
    output logic [NCH-1:0] clock_out,
    output logic [NCH-1:0] tick
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] pend;
    logic [NCH-1:0] ld_we_c;
    logic           ready_c;

    // Channel decode; an out-of-range load_ch is never ready
    always_comb begin
        ready_c = 1'b0;
        ld_we_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ld.load_ch == CHW'(i)) begin
                ready_c    = !pend[i];
                ld_we_c[i] = ld.load_valid && !pend[i];
            end
        end
    end

    assign ld.load_ready = ready_c;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkdiv_channel #(
            .CW         (CW),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .clk       (clock_in),
            .rst_n     (reset_n),
            .en        (en[g]),
`ifdef CLKDIV_SYNC_EN
            .sync_in   (sync_in),
`endif
            .ld_we     (ld_we_c[g]),
            .ld_period (ld.load_period),
            .ld_high   (ld.load_high),
            .pending   (pend[g]),
            .clock_out (clock_out[g]),
            .tick      (tick[g])
        );
    end

endmodule : clkdiv_bank
